// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates one instruction-fetch port and one data port onto a single-beat memory bus.
// Latency: grant in IDLE, one or more BUSY cycles until ready&last, then a one-cycle DONE response pulse.
// Backpressure: the memory bus stalls BUSY via oresp.ready; core requests are re-sampled only in IDLE.
//
// Ports:
//   clk, reset      - clock and synchronous active-high reset
//   ireq / iresp    - instruction fetch request / response (32-bit data, addr[2] selects the half)
//   dreq / dresp    - data request / response (full 64-bit data)
//   oreq / oresp    - memory bus request (driven only from holding registers) / response
// Configuration:
//   MEM_ARBITER_RR_EN - when defined, ties alternate strictly between the two sides and the
//                       starvation counter is not built; otherwise data wins ties until the
//                       instruction side has waited STARVE_LIMIT consecutive data grants.

typedef struct packed {
    logic        valid;
    logic [63:0] addr;
} ibus_req_t;

typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
} ibus_resp_t;

typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
} dbus_req_t;

typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
} dbus_resp_t;

typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [3:0]  len;
} cbus_req_t;

typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
} cbus_resp_t;

module mem_arbiter #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  ibus_req_t  ireq,
    output ibus_resp_t iresp,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output cbus_req_t  oreq,
    input  cbus_resp_t oresp
);

    localparam logic [2:0] MSIZE4 = 3'd2;
    localparam logic [3:0] MLEN1  = 4'd0;

    typedef enum logic [2:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        DONE_I,
        DONE_D
    } state_t;

    state_t      state;
    logic        oreq_vld;
    logic        i_ok;
    logic        d_ok;
    logic [63:0] hold_addr;
    logic [2:0]  hold_size;
    logic [7:0]  hold_strobe;
    logic [63:0] hold_data;
    logic        hold_write;
    logic [63:0] rdata;

    logic        i_pend;
    logic        d_pend;
    logic        grant_i;
    logic        grant_d;

`ifdef MEM_ARBITER_RR_EN
    // Side that won the previous grant; starts as instruction so data wins the first tie.
    logic        last_i;
`else
    localparam int             CW        = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0]  CNT_LIMIT = CW'(STARVE_LIMIT);
    logic [CW-1:0]             starve_cnt;
`endif

    // A misaligned fetch is never issued by the core, so it is simply never considered pending.
    assign i_pend = ireq.valid && (ireq.addr[1:0] == 2'b00);
    assign d_pend = dreq.valid;

`ifdef MEM_ARBITER_RR_EN
    assign grant_i = i_pend && (!d_pend || !last_i);
`else
    assign grant_i = i_pend && (!d_pend || (starve_cnt == CNT_LIMIT));
`endif
    assign grant_d = d_pend && !grant_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            oreq_vld    <= 1'b0;
            i_ok        <= 1'b0;
            d_ok        <= 1'b0;
            hold_addr   <= '0;
            hold_size   <= '0;
            hold_strobe <= '0;
            hold_data   <= '0;
            hold_write  <= 1'b0;
            rdata       <= '0;
`ifdef MEM_ARBITER_RR_EN
            last_i      <= 1'b1;
`else
            starve_cnt  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_i) begin
                        hold_addr   <= ireq.addr;
                        hold_size   <= MSIZE4;
                        hold_strobe <= '0;
                        hold_data   <= '0;
                        hold_write  <= 1'b0;
                        oreq_vld    <= 1'b1;
                        state       <= BUSY_I;
`ifdef MEM_ARBITER_RR_EN
                        last_i      <= 1'b1;
`else
                        starve_cnt  <= '0;
`endif
                    end else if (grant_d) begin
                        hold_addr   <= dreq.addr;
                        hold_size   <= dreq.size;
                        hold_strobe <= dreq.strobe;
                        hold_data   <= dreq.data;
                        hold_write  <= |dreq.strobe;
                        oreq_vld    <= 1'b1;
                        state       <= BUSY_D;
`ifdef MEM_ARBITER_RR_EN
                        last_i      <= 1'b0;
`else
                        // Count only grants that made a waiting fetch wait longer.
                        if (!i_pend)
                            starve_cnt <= '0;
                        else if (starve_cnt != CNT_LIMIT)
                            starve_cnt <= starve_cnt + 1'b1;
`endif
                    end
                end
                BUSY_I: begin
                    if (oresp.ready && oresp.last) begin
                        rdata    <= oresp.data;
                        oreq_vld <= 1'b0;
                        i_ok     <= 1'b1;
                        state    <= DONE_I;
                    end
                end
                BUSY_D: begin
                    if (oresp.ready && oresp.last) begin
                        rdata    <= oresp.data;
                        oreq_vld <= 1'b0;
                        d_ok     <= 1'b1;
                        state    <= DONE_D;
                    end
                end
                DONE_I: begin
                    i_ok  <= 1'b0;
                    state <= IDLE;
                end
                DONE_D: begin
                    d_ok  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        oreq          = '0;
        oreq.valid    = oreq_vld;
        oreq.is_write = hold_write;
        oreq.size     = hold_size;
        oreq.addr     = hold_addr;
        oreq.strobe   = hold_strobe;
        oreq.data     = hold_data;
        oreq.len      = MLEN1;

        iresp         = '0;
        iresp.addr_ok = i_ok;
        iresp.data_ok = i_ok;
        iresp.data    = hold_addr[2] ? rdata[63:32] : rdata[31:0];

        dresp         = '0;
        dresp.addr_ok = d_ok;
        dresp.data_ok = d_ok;
        dresp.data    = rdata;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter (STARVE_LIMIT=2).
// Latency: checks grant -> BUSY -> DONE timing with hand-computed expected values.
// Backpressure: the bench plays the memory bus and holds oresp.ready low to stall BUSY.

module tb_mem_arbiter;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } t_ireq;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } t_iresp;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } t_dreq;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } t_dresp;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic [3:0]  len;
    } t_oreq;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } t_oresp;

    logic   clk = 1'b0;
    logic   reset;
    t_ireq  ireq;
    t_iresp iresp;
    t_dreq  dreq;
    t_dresp dresp;
    t_oreq  oreq;
    t_oresp oresp;

    int n_checks = 0;
    int n_errors = 0;

    mem_arbiter #(.STARVE_LIMIT(2)) dut (
        .clk   (clk),
        .reset (reset),
        .ireq  (ireq),
        .iresp (iresp),
        .dreq  (dreq),
        .dresp (dresp),
        .oreq  (oreq),
        .oresp (oresp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ireq  = '0;
        dreq  = '0;
        oresp = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    // Single fetch with the bus answering on the first BUSY cycle.
    task automatic do_fetch(input logic [63:0] addr, input logic [63:0] bus_data,
                            input logic [31:0] exp_data);
        oresp.ready = 1'b1;
        oresp.last  = 1'b1;
        oresp.data  = bus_data;
        ireq.valid  = 1'b1;
        ireq.addr   = addr;
        step();                                   // grant edge -> BUSY_I
        chk("fetch_busy_valid", oreq.valid, 1);
        chk("fetch_busy_addr", oreq.addr, addr);
        chk("fetch_is_write", oreq.is_write, 0);
        chk("fetch_size", oreq.size, 2);
        chk("fetch_strobe", oreq.strobe, 0);
        chk("fetch_len", oreq.len, 0);
        chk("fetch_early_ok", iresp.data_ok, 0);
        ireq.valid = 1'b0;
        step();                                   // ready&last sampled -> DONE_I
        chk("fetch_data_ok", iresp.data_ok, 1);
        chk("fetch_addr_ok", iresp.addr_ok, 1);
        chk("fetch_data", iresp.data, exp_data);
        chk("fetch_valid_drop", oreq.valid, 0);
        chk("fetch_no_dresp", dresp.data_ok, 0);
        step();                                   // back to IDLE
        chk("fetch_ok_pulse_end", iresp.data_ok, 0);
        oresp = '0;
    endtask

    initial begin
        string      exp_seq;
        byte        got_seq[$];
        int         both_ok;
        logic [7:0] exp_c;

        // Reset state.
        do_reset();
        chk("rst_oreq_valid", oreq.valid, 0);
        chk("rst_iresp_ok", iresp.data_ok, 0);
        chk("rst_dresp_ok", dresp.data_ok, 0);
        chk("rst_dresp_data", dresp.data, 0);
        chk("rst_oreq_addr", oreq.addr, 0);

        // Fetches: addr[2]=1 selects the upper half, addr[2]=0 the lower half.
        do_fetch(64'h8000_0004, 64'h1111_2222_3333_4444, 32'h1111_2222);
        do_fetch(64'h8000_0000, 64'h1111_2222_3333_4444, 32'h3333_4444);

        // Store held on the bus until ready&last.
        oresp      = '0;
        dreq.valid  = 1'b1;
        dreq.addr   = 64'h8000_0010;
        dreq.size   = 3'd3;
        dreq.strobe = 8'h0F;
        dreq.data   = 64'hAABB;
        step();
        chk("st_valid", oreq.valid, 1);
        chk("st_is_write", oreq.is_write, 1);
        chk("st_strobe", oreq.strobe, 8'h0F);
        chk("st_data", oreq.data, 64'hAABB);
        chk("st_addr", oreq.addr, 64'h8000_0010);
        chk("st_size", oreq.size, 3);
        dreq.valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("st_held_valid", oreq.valid, 1);
            chk("st_held_no_ok", dresp.data_ok, 0);
        end
        oresp.ready = 1'b1;
        oresp.last  = 1'b1;
        oresp.data  = 64'h0123_4567_89AB_CDEF;
        step();
        chk("st_data_ok", dresp.data_ok, 1);
        chk("st_addr_ok", dresp.addr_ok, 1);
        chk("st_resp_data", dresp.data, 64'h0123_4567_89AB_CDEF);
        chk("st_no_iresp", iresp.data_ok, 0);
        oresp = '0;
        step();
        chk("st_ok_pulse_end", dresp.data_ok, 0);
        chk("st_valid_end", oreq.valid, 0);

        // Load with a slow bus; request changes during BUSY must not reach the bus.
        dreq.valid  = 1'b1;
        dreq.addr   = 64'h8000_0020;
        dreq.size   = 3'd3;
        dreq.strobe = 8'h00;
        dreq.data   = 64'h0;
        step();
        chk("ld_is_write", oreq.is_write, 0);
        dreq.valid  = 1'b0;
        dreq.addr   = 64'hDEAD_0000;
        dreq.strobe = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            // One cycle of ready without last must not complete the access.
            oresp.ready = (i == 2);
            oresp.last  = 1'b0;
            step();
            chk("ld_addr_stable", oreq.addr, 64'h8000_0020);
            chk("ld_no_ok", dresp.data_ok, 0);
        end
        oresp.ready = 1'b1;
        oresp.last  = 1'b1;
        oresp.data  = 64'hCAFE_F00D_1234_5678;
        step();
        chk("ld_data_ok", dresp.data_ok, 1);
        chk("ld_data", dresp.data, 64'hCAFE_F00D_1234_5678);
        oresp = '0;
        step();

        // Reset in BUSY_I aborts the fetch without a response.
        ireq.valid = 1'b1;
        ireq.addr  = 64'h8000_0008;
        step();
        chk("rb_busy", oreq.valid, 1);
        reset      = 1'b1;
        ireq.valid = 1'b0;
        step();
        chk("rb_valid_off", oreq.valid, 0);
        chk("rb_no_ok", iresp.data_ok, 0);
        reset       = 1'b0;
        oresp.ready = 1'b1;
        oresp.last  = 1'b1;
        oresp.data  = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rb_idle_ready_ignored", oreq.valid | iresp.data_ok, 0);
        end
        do_fetch(64'h8000_0008, 64'h5555_6666_7777_8888, 32'h7777_8888);

        // Misaligned fetch is never granted.
        ireq.valid = 1'b1;
        ireq.addr  = 64'h8000_0002;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mis_no_grant", oreq.valid, 0);
        end
        ireq.valid = 1'b0;

        // Both sides held: record the grant order from the bus addresses.
        do_reset();
`ifdef MEM_ARBITER_RR_EN
        exp_seq = "DIDIDI";
`else
        exp_seq = "DDIDDI";
`endif
        ireq.valid  = 1'b1;
        ireq.addr   = 64'h0000_1000;
        dreq.valid  = 1'b1;
        dreq.addr   = 64'h0000_2000;
        dreq.size   = 3'd3;
        dreq.strobe = 8'h00;
        oresp.ready = 1'b1;
        oresp.last  = 1'b1;
        oresp.data  = 64'h0;
        both_ok     = 0;
        for (int c = 0; c < 60 && got_seq.size() < 6; c++) begin
            step();
            if (oreq.valid)
                got_seq.push_back(oreq.addr[13] ? "D" : "I");
            if (iresp.data_ok && dresp.data_ok)
                both_ok++;
        end
        chk("order_count", 64'(got_seq.size()), 6);
        for (int i = 0; i < got_seq.size(); i++) begin
            exp_c = exp_seq[i];
            chk($sformatf("order_%0d", i), got_seq[i], exp_c);
        end
        chk("order_exclusive_ok", 64'(both_ok), 0);
        ireq = '0;
        dreq = '0;
        oresp = '0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 8, is the maximum number of consecutive data grants while ireq.valid is pending; the next grant then SHALL go to instruction.
REQ-002 clk  input  1  system clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ireq  input  ibus_req_t  core fetch request (valid, addr[63:0]).
REQ-005 iresp  output  ibus_resp_t  fetch response (addr_ok, data_ok, data[31:0]).
REQ-006 dreq  input  dbus_req_t  core data request (valid, addr, size, strobe, data).
REQ-007 dresp  output  dbus_resp_t  data response (addr_ok, data_ok, data[63:0]).
REQ-008 oreq  output  cbus_req_t  single memory-bus request (valid, is_write, size, addr, strobe, data, len=single beat).
REQ-009 oresp  input  cbus_resp_t  memory-bus response (ready, last, data[63:0]).

Function
REQ-010 FSM states SHALL be IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D.
REQ-011 IDLE: request pending SHALL latch addr/size/strobe/data of granted side into holding registers and move to BUSY_I or BUSY_D next cycle.
REQ-012 Grant with both pending: dreq wins unless starve counter == STARVE_LIMIT, then ireq wins.
REQ-013 Starve counter SHALL increment on each data grant while ireq.valid=1, clear on any instruction grant or when ireq.valid=0 at grant; saturate at STARVE_LIMIT.
REQ-014 BUSY_x: oreq.valid=1, fields driven only from holding registers; changes on ireq/dreq SHALL be ignored.
REQ-015 Instruction access: is_write=0, size=MSIZE4, strobe=0, addr=latched ireq.addr.
REQ-016 Data access: is_write=(strobe!=0), size/strobe/data/addr from latched dreq.
REQ-017 BUSY_x with oresp.ready && oresp.last: capture oresp.data into response register, go DONE_x next cycle; oreq.valid deasserts that following cycle.
REQ-018 DONE_I: exactly one cycle with iresp.addr_ok=iresp.data_ok=1, iresp.data = latched addr[2] ? rdata[63:32] : rdata[31:0]; then IDLE.
REQ-019 DONE_D: exactly one cycle with dresp.addr_ok=dresp.data_ok=1, dresp.data = full 64-bit captured word (no shifting); then IDLE.
REQ-020 The non-granted side's data_ok/addr_ok SHALL stay 0 throughout.
REQ-021 Minimum latency, grant to data_ok: 3 cycles (IDLE grant, BUSY with ready=1, DONE).
REQ-022 IDLE cannot re-grant in same cycle as a DONE pulse; request held after data_ok SHALL be re-sampled as new request in next IDLE cycle.
REQ-023 ireq.valid=1 with addr[1:0]!=0 SHALL never be granted (core never issues it).
REQ-024 oresp.ready outside BUSY_x SHALL be ignored.

Reset
REQ-025 Reset SHALL force IDLE, clear starve counter, holding and response registers to 0, and drive oreq.valid, all addr_ok/data_ok to 0 from the next cycle.
REQ-026 Reset mid-transaction (BUSY_x or DONE_x) SHALL abort without emitting data_ok; pending response data discarded.

Configuration
REQ-027 Macro MEM_ARBITER_RR_EN: when defined, with both pending, grant SHALL alternate strictly (last-granted side loses); starve counter and STARVE_LIMIT unused; last-granted reset value = instruction, so data wins first tie.
REQ-028 Without MEM_ARBITER_RR_EN: data priority with starvation limit per REQ-012/013.

Verification
REQ-029 Single fetch ireq.addr=0x8000_0004, oresp.ready=1 on first BUSY cycle with data 0x1111_2222_3333_4444 -> iresp.data_ok pulse 3 cycles after grant, data=0x1111_2222.
REQ-030 Store dreq addr=0x8000_0010 strobe=0x0F data=0xAABB -> oreq is_write=1, strobe=0x0F, held until ready&last; dresp.data_ok single pulse.
REQ-031 ireq and dreq both held continuously, RR undefined, STARVE_LIMIT=2 -> grant order D,D,I,D,D,I.
REQ-032 Same stimulus, MEM_ARBITER_RR_EN defined -> grant order D,I,D,I.
REQ-033 oresp.ready delayed 5 cycles, dreq.addr changed during BUSY_D -> oreq.addr stays original; data_ok on cycle after ready.
REQ-034 Reset asserted in BUSY_I -> next cycle IDLE, oreq.valid=0, no iresp.data_ok; later fetch completes normally.
